alu_exec_unit: RTL and testbench

// - Parametrised integer execute unit for the RV32I core, successor to the I-type datapath.
// - Executes all OP-IMM and OP (R-type) funct3 operations at XLEN width.
// - valid/ready handshakes on both input and output.
// - Shifts run iteratively, SHIFT_STEP bits/cycle; all other ops complete in 1 cycle.
// - Sits between decode/regfile read and writeback; also the base for the multi-cycle core.

---
 rtl/alu_exec_unit.sv | 185 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// RV32I integer execute unit (OP / OP-IMM) with valid/ready handshakes on both sides.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic            is_imm_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int unsigned ShW = $clog2(XLEN);

  localparam logic [2:0] F3Add  = 3'b000;
  localparam logic [2:0] F3Sll  = 3'b001;
  localparam logic [2:0] F3Slt  = 3'b010;
  localparam logic [2:0] F3Sltu = 3'b011;
  localparam logic [2:0] F3Xor  = 3'b100;
  localparam logic [2:0] F3Sr   = 3'b101;
  localparam logic [2:0] F3Or   = 3'b110;
  localparam logic [2:0] F3And  = 3'b111;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [0:0] {StIdle, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_res;
  logic [ShW-1:0]  shamt;
  logic            sub_op;
  logic            accept;

  assign shamt  = op_b_i[ShW-1:0];
  assign sub_op = !is_imm_i && funct7b5_i;
  assign accept = in_valid_i && in_ready_o;

`ifdef ALU_BARREL_SHIFT_EN
  logic [XLEN-1:0] sra_res;
  assign sra_res = $signed(op_a_i) >>> shamt;
`else
  localparam logic [ShW:0] StepAmt = (ShW + 1)'(SHIFT_STEP);

  logic [XLEN-1:0] work_q, work_d;
  logic [ShW-1:0]  cnt_q, cnt_d;
  logic            sra_q, sra_d;
  logic            left_q, left_d;
  logic [ShW:0]    cnt_ext, step_amt;
  logic [ShW-1:0]  cnt_rem;
  logic [XLEN-1:0] shl_val, shr_val, sra_val, shifted;
  logic            is_shift;

  assign is_shift = (funct3_i == F3Sll) || (funct3_i == F3Sr);
  assign cnt_ext  = {1'b0, cnt_q};
  // Final step may be shorter than SHIFT_STEP so the total never overshoots shamt.
  assign step_amt = (cnt_ext >= StepAmt) ? StepAmt : cnt_ext;
  assign cnt_rem  = cnt_q - step_amt[ShW-1:0];
  assign shl_val  = work_q << step_amt;
  assign shr_val  = work_q >> step_amt;
  assign sra_val  = $signed(work_q) >>> step_amt;

  always_comb begin
    shifted = shr_val;
    if (left_q) begin
      shifted = shl_val;
    end else if (sra_q) begin
      shifted = sra_val;
    end
  end
`endif

  always_comb begin
    alu_res = '0;
    unique case (funct3_i)
      F3Add:  alu_res = sub_op ? (op_a_i - op_b_i) : (op_a_i + op_b_i);
      F3Slt:  alu_res = {{(XLEN - 1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
      F3Sltu: alu_res = {{(XLEN - 1){1'b0}}, op_a_i < op_b_i};
      F3Xor:  alu_res = op_a_i ^ op_b_i;
      F3Or:   alu_res = op_a_i | op_b_i;
      F3And:  alu_res = op_a_i & op_b_i;
`ifdef ALU_BARREL_SHIFT_EN
      F3Sll:  alu_res = op_a_i << shamt;
      F3Sr:   alu_res = funct7b5_i ? sra_res : (op_a_i >> shamt);
`else
      // Only reached with shamt == 0; non-zero shifts go through StShift.
      F3Sll, F3Sr: alu_res = op_a_i;
`endif
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      result_q <= '0;
`ifndef ALU_BARREL_SHIFT_EN
      work_q   <= '0;
      cnt_q    <= '0;
      sra_q    <= 1'b0;
      left_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifndef ALU_BARREL_SHIFT_EN
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sra_q    <= sra_d;
      left_q   <= left_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifndef ALU_BARREL_SHIFT_EN
    work_d   = work_q;
    cnt_d    = cnt_q;
    sra_d    = sra_q;
    left_d   = left_q;
`endif
    unique case (state_q)
      StIdle: ;
`ifndef ALU_BARREL_SHIFT_EN
      StShift: begin
        work_d = shifted;
        cnt_d  = cnt_rem;
        if (cnt_rem == '0) begin
          result_d = shifted;
          state_d  = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept is only possible from StIdle or a draining StDone.
    if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (is_shift && (shamt != '0)) begin
        work_d  = op_a_i;
        cnt_d   = shamt;
        sra_d   = (funct3_i == F3Sr) && funct7b5_i;
        left_d  = (funct3_i == F3Sll);
        state_d = StShift;
      end else begin
        result_d = alu_res;
        state_d  = StDone;
      end
`else
      result_d = alu_res;
      state_d  = StDone;
`endif
    end
  end

  // Outputs
  always_comb begin
    in_ready_o  = !rst_i &&
                  ((state_q == StIdle) || ((state_q == StDone) && out_ready_i));
    out_valid_o = (state_q == StDone);
    busy_o      = (state_q != StIdle);
    result_o    = result_q;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table plus handshake/reset corner sequences.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sel4 = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        is_imm = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_ready = 1'b1;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] result1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] result4;
  logic        cur_ready, cur_valid;
  logic [31:0] cur_result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        use4;
    logic [2:0]  f3;
    logic        f7;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid && !sel4),
    .in_ready_o (in_ready1),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .is_imm_i   (is_imm),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .out_valid_o(out_valid1),
    .out_ready_i(out_ready),
    .result_o   (result1),
    .busy_o     (busy1)
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid && sel4),
    .in_ready_o (in_ready4),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .is_imm_i   (is_imm),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .out_valid_o(out_valid4),
    .out_ready_i(out_ready),
    .result_o   (result4),
    .busy_o     (busy4)
  );

  assign cur_ready  = sel4 ? in_ready4 : in_ready1;
  assign cur_valid  = sel4 ? out_valid4 : out_valid1;
  assign cur_result = sel4 ? result4 : result1;

  function automatic int shift_lat(int shamt, int step);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (shamt == 0) return 1;
    return (shamt + step - 1) / step + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   waited;
    int   cyc;
    exp_t e;
    @(negedge clk);
    sel4      = v.use4;
    funct3    = v.f3;
    funct7b5  = v.f7;
    is_imm    = v.imm;
    op_a      = v.a;
    op_b      = v.b;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    waited    = 0;
    while (!cur_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!cur_ready) begin
      check($sformatf("vec%0d_accept_timeout", idx), 32'(cur_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{res: v.exp, lat: v.lat});
    @(posedge clk);
    #1;
    // Scramble inputs: the op in flight must use only the values seen at accept.
    in_valid = 1'b0;
    op_a     = ~v.a;
    op_b     = ~v.b;
    funct3   = ~v.f3;
    funct7b5 = ~v.f7;
    @(negedge clk);
    cyc = 1;
    while (!cur_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    if (!cur_valid) begin
      check($sformatf("vec%0d_out_timeout", idx), 32'(cur_valid), 32'd1);
      return;
    end
    check($sformatf("vec%0d_result", idx), cur_result, e.res);
    check($sformatf("vec%0d_latency", idx), 32'(cyc), 32'(e.lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   ov_count;

    vecs[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1};
    vecs[1]  = '{1'b0, 3'b000, 1'b1, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1};
    vecs[2]  = '{1'b0, 3'b000, 1'b1, 1'b1, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 1};
    vecs[3]  = '{1'b0, 3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    vecs[4]  = '{1'b0, 3'b011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vecs[5]  = '{1'b0, 3'b100, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1};
    vecs[6]  = '{1'b0, 3'b110, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1};
    vecs[7]  = '{1'b0, 3'b111, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1};
    vecs[8]  = '{1'b0, 3'b101, 1'b1, 1'b0, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF,
                 shift_lat(31, 1)};
    vecs[9]  = '{1'b0, 3'b101, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000001,
                 shift_lat(31, 1)};
    vecs[10] = '{1'b0, 3'b001, 1'b0, 1'b0, 32'h12345678, 32'h00000020, 32'h12345678, 1};
    vecs[11] = '{1'b0, 3'b001, 1'b0, 1'b1, 32'h00000001, 32'h00000004, 32'h00000010,
                 shift_lat(4, 1)};
    vecs[12] = '{1'b0, 3'b101, 1'b1, 1'b1, 32'hF0000000, 32'h00000004, 32'hFF000000,
                 shift_lat(4, 1)};
    vecs[13] = '{1'b1, 3'b101, 1'b1, 1'b0, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF,
                 shift_lat(31, 4)};
    vecs[14] = '{1'b1, 3'b001, 1'b0, 1'b0, 32'h00000003, 32'h00000005, 32'h00000060,
                 shift_lat(5, 4)};
    vecs[15] = '{1'b0, 3'b011, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1};

    // Reset held two cycles with a request pending: nothing may be accepted.
    rst      = 1'b1;
    in_valid = 1'b1;
    op_a     = 32'h11111111;
    op_b     = 32'h22222222;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d_out_valid", i), 32'(out_valid1), 32'd0);
      check($sformatf("rst%0d_result", i), result1, 32'd0);
      check($sformatf("rst%0d_busy", i), 32'(busy1), 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);
    check("post_rst_no_output", 32'(out_valid1), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: result held for 5 cycles while a second op waits, then accepted on drain.
    @(negedge clk);
    sel4      = 1'b0;
    funct3    = 3'b000;
    funct7b5  = 1'b0;
    is_imm    = 1'b0;
    op_a      = 32'd3;
    op_b      = 32'd4;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    check("bp_first_in_ready", 32'(in_ready1), 32'd1);
    sb.push_back('{res: 32'd7, lat: 1});
    @(posedge clk);
    #1;
    funct3 = 3'b100;
    op_a   = 32'hF0F0F0F0;
    op_b   = 32'h0FF00FF0;
    e      = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid1), 32'd1);
      check($sformatf("bp%0d_result", k), result1, e.res);
      check($sformatf("bp%0d_in_ready", k), 32'(in_ready1), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_drain_in_ready", 32'(in_ready1), 32'd1);
    sb.push_back('{res: 32'hFF00FF00, lat: 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    check("bp_second_out_valid", 32'(out_valid1), 32'd1);
    check("bp_second_result", result1, e.res);
    @(negedge clk);
    check("bp_idle_busy", 32'(busy1), 32'd0);

`ifndef ALU_BARREL_SHIFT_EN
    // Reset in the middle of a long shift: the op is dropped silently.
    @(negedge clk);
    funct3   = 3'b101;
    funct7b5 = 1'b0;
    op_a     = 32'h0000FFFF;
    op_b     = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("shift%0d_in_ready", k), 32'(in_ready1), 32'd0);
      check($sformatf("shift%0d_busy", k), 32'(busy1), 32'd1);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    ov_count = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid1) ov_count++;
    end
    check("rst_shift_no_output", 32'(ov_count), 32'd0);
    check("rst_shift_busy", 32'(busy1), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
